fifo_relay: RTL and testbench

- Credit-based relay station placed between two `fifo` instances on a long inter-slot stream.
- Drains the read side of the upstream fifo through LEVEL pipeline registers into a small local FWFT buffer.
- Drives the write side of the downstream fifo.
- Credit counting guarantees the local buffer never overflows, so no combinational path crosses the relay; sustains 1 word/cycle.

---
 rtl/relay_pkg.sv | 31 +++
 rtl/fifo_relay_buf.sv | 62 ++++++
 rtl/fifo_relay.sv | 85 ++++++++
 tb/tb_fifo_relay.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared helpers for the fifo_relay credit-based relay station: width
// computation and parameter legality predicates.
package relay_pkg;

  localparam int unsigned MaxLevel = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

  // Credit and occupancy counters must hold the value BUF_DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  function automatic bit level_ok(input int unsigned level);
    return (level >= 1) && (level <= MaxLevel);
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return depth >= 1;
  endfunction

endpackage

// File: rtl/fifo_relay_buf.sv
// First-word-fall-through circular buffer local to the relay station.
// Depth need not be a power of two; pointers wrap explicitly.
module fifo_relay_buf
  import relay_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 4,
  parameter int unsigned CntWidth = cnt_width(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic [Width-1:0]    head_o,
  output logic [CntWidth-1:0] count_o
);

  localparam int unsigned PtrWidth = ptr_width(Depth);
  localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] head_q, head_d;
  logic [PtrWidth-1:0] tail_q, tail_d;
  logic [CntWidth-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i) head_d = (head_q == PtrLast) ? '0 : head_q + PtrOne;
    if (push_i) tail_d = (tail_q == PtrLast) ? '0 : tail_q + PtrOne;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[tail_q] <= data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/fifo_relay.sv
// Credit-based relay station between two fifos: LEVEL forward register stages
// feeding a local FWFT buffer, with no combinational path across the relay.
module fifo_relay
  import relay_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEVEL      = 2,
  parameter int unsigned BUF_DEPTH  = LEVEL + 2,
  parameter int unsigned CNT_WIDTH  = cnt_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_empty_n,
  input  logic [DATA_WIDTH-1:0] i_dout,
  output logic                  i_read,
  output logic                  i_read_ce,
  input  logic                  o_full_n,
  output logic                  o_write,
  output logic                  o_write_ce,
  output logic [DATA_WIDTH-1:0] o_din,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  if (!level_ok(LEVEL)) begin : g_bad_level
    $error("fifo_relay: LEVEL must be within 1..8");
  end
  if (!depth_ok(BUF_DEPTH)) begin : g_bad_depth
    $error("fifo_relay: BUF_DEPTH must be at least 1");
  end

  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntDepth = CNT_WIDTH'(BUF_DEPTH);

  logic [LEVEL-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] data_q [LEVEL];
  logic [CNT_WIDTH-1:0]  credits_q, credits_d;
  logic [DATA_WIDTH-1:0] buf_head;

  // A pop is only issued with credit in hand, so the buffer can never overflow.
  assign i_read     = reset_n & i_empty_n & (credits_q != '0);
  assign i_read_ce  = 1'b1;
  assign o_write_ce = 1'b1;
  assign o_write    = (occupancy != '0) & o_full_n;
  assign o_din      = (occupancy != '0) ? buf_head : '0;

  always_comb begin
    credits_d = credits_q;
    unique case ({i_read, o_write})
      2'b10:   credits_d = credits_q - CntOne;
      2'b01:   credits_d = credits_q + CntOne;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits_q <= CntDepth;
      valid_q   <= '0;
      for (int k = 0; k < LEVEL; k++) data_q[k] <= '0;
    end else begin
      credits_q <= credits_d;
      valid_q[0] <= i_read;
      data_q[0]  <= i_dout;
      for (int k = 1; k < LEVEL; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  fifo_relay_buf #(
    .Width    (DATA_WIDTH),
    .Depth    (BUF_DEPTH),
    .CntWidth (CNT_WIDTH)
  ) u_buf (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (valid_q[LEVEL-1]),
    .data_i  (data_q[LEVEL-1]),
    .pop_i   (o_write),
    .head_o  (buf_head),
    .count_o (occupancy)
  );

endmodule

// File: tb/tb_fifo_relay.sv
// Self-checking bench for fifo_relay: a queue-based model of words in flight
// and words buffered predicts every output each cycle.
module tb_fifo_relay;

  localparam int DW = 32;
  localparam int LV = 2;
  localparam int BD = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [31:0] rc;
    logic [31:0] d;
  } flight_t;

  logic          clk;
  logic          reset_n;
  logic          i_empty_n;
  logic [DW-1:0] i_dout;
  logic          i_read;
  logic          i_read_ce;
  logic          o_full_n;
  logic          o_write;
  logic          o_write_ce;
  logic [DW-1:0] o_din;
  logic [CW-1:0] occupancy;

  fifo_relay #(
    .DATA_WIDTH (DW),
    .LEVEL      (LV),
    .BUF_DEPTH  (BD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_empty_n  (i_empty_n),
    .i_dout     (i_dout),
    .i_read     (i_read),
    .i_read_ce  (i_read_ce),
    .o_full_n   (o_full_n),
    .o_write    (o_write),
    .o_write_ce (o_write_ce),
    .o_din      (o_din),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_asrt = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned out_seen = 0;
  int unsigned out_model = 0;
  logic en;
  logic [DW-1:0] src[$];
  flight_t       pipe[$];
  logic [DW-1:0] rbuf[$];
  logic          obs_rd, obs_wr;
  logic [DW-1:0] obs_din;
  logic [CW-1:0] obs_occ;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: present upstream head, check at negedge, advance model at posedge.
  task automatic cycle();
    logic          exp_rd, exp_wr;
    logic [DW-1:0] exp_din;
    flight_t       f;
    i_empty_n = en && (src.size() != 0);
    i_dout    = (src.size() != 0) ? src[0] : '0;
    @(negedge clk);
    exp_wr  = (rbuf.size() != 0) && o_full_n;
    exp_din = (rbuf.size() != 0) ? rbuf[0] : '0;
    exp_rd  = reset_n && i_empty_n && ((pipe.size() + rbuf.size()) < BD);
    obs_rd = i_read; obs_wr = o_write; obs_din = o_din; obs_occ = occupancy;
    chk("i_read", 64'(i_read), 64'(exp_rd));
    chk("o_write", 64'(o_write), 64'(exp_wr));
    chk("o_din", 64'(o_din), 64'(exp_din));
    chk("occupancy", 64'(occupancy), 64'(rbuf.size()));
    chk("credits", 64'(dut.credits_q), 64'(BD - pipe.size() - rbuf.size()));
    chk("ce_const", 64'({i_read_ce, o_write_ce}), 64'(2'b11));
    if (o_write) out_seen++;
    @(posedge clk);
    if (exp_wr) begin
      void'(rbuf.pop_front());
      out_model++;
    end
    if (pipe.size() != 0 && pipe[0].rc + LV == cyc) begin
      f = pipe.pop_front();
      rbuf.push_back(f.d);
    end
    if (exp_rd) begin
      f.rc = cyc;
      f.d  = src.pop_front();
      pipe.push_back(f);
    end
    cyc++;
    #1;
  endtask

  initial begin
    int unsigned first_wr, n_wr, run, max_run, start, max_occ;
    logic seen;

    // Reset with upstream data available and downstream free.
    reset_n = 1'b0; en = 1'b1; o_full_n = 1'b1; i_empty_n = 1'b0; i_dout = '0;
    src.push_back(32'h0000_0011);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_outputs", 64'({obs_rd, obs_wr, obs_din, obs_occ}), 64'(0));
    end
    reset_n = 1'b1;
    cycle();
    chk("rd_after_release", 64'(obs_rd), 64'(1));
    en = 1'b0;
    while (cyc < 10) cycle();

    // Single word latency: read at cycle 10, pushed downstream at cycle 13.
    src.push_back(32'hA5A5_A5A5);
    en = 1'b1;
    cycle();
    chk("lat_read", 64'(obs_rd), 64'(1));
    en = 1'b0;
    cycle();
    chk("lat_t1", 64'(obs_wr), 64'(0));
    cycle();
    chk("lat_t2", 64'(obs_wr), 64'(0));
    cycle();
    chk("lat_t3", 64'({obs_wr, obs_din}), 64'({1'b1, 32'hA5A5_A5A5}));
    chk("lat_cycle", 64'(cyc - 1), 64'(13));

    // Full throughput: 100 words, both ends free.
    for (int i = 0; i < 100; i++) src.push_back(i);
    en = 1'b1; start = cyc; first_wr = 0; n_wr = 0; run = 0; max_run = 0; seen = 1'b0;
    for (int i = 0; i < 110; i++) begin
      cycle();
      if (obs_wr) begin
        if (!seen) first_wr = cyc - 1;
        seen = 1'b1; n_wr++; run++;
        if (run > max_run) max_run = run;
      end else run = 0;
    end
    chk("tput_first", 64'(first_wr), 64'(start + 3));
    chk("tput_count", 64'(n_wr), 64'(100));
    chk("tput_run", 64'(max_run), 64'(100));

    // Downstream stall for 30 cycles during a continuous random stream.
    for (int i = 0; i < 200; i++) src.push_back($urandom);
    max_occ = 0;
    for (int i = 0; i < 100; i++) begin
      o_full_n = !(i >= 20 && i < 50);
      cycle();
      if (obs_occ > max_occ) max_occ = obs_occ;
      if (i == 49) chk("stall_rd_low", 64'({obs_rd, obs_occ}), 64'({1'b0, 3'd4}));
      if (i == 70) chk("stall_resume", 64'({obs_rd, obs_wr}), 64'(2'b11));
    end
    chk("stall_max_occ", 64'(max_occ), 64'(BD));

    // Alternating downstream space with bursty upstream.
    for (int i = 0; i < 200; i++) src.push_back($urandom);
    for (int i = 0; i < 200; i++) begin
      o_full_n = cyc[0];
      en = 1'($urandom_range(0, 1));
      cycle();
    end

    // Mid-stream reset while words are in flight and buffered.
    o_full_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    reset_n = 1'b0;
    #1;
    chk("midrst_async", 64'({i_read, o_write, o_din, occupancy}), 64'(0));
    chk("midrst_credits", 64'(dut.credits_q), 64'(BD));
    pipe.delete();
    rbuf.delete();
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) cycle();

    // Drain and confirm nothing was lost or duplicated.
    en = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    chk("drain_occ", 64'(obs_occ), 64'(0));
    chk("out_count", 64'(out_seen), 64'(out_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
